// File: rtl/fetch_pkg.sv
// Shared fetch-path types and decode-consume encodings.
// Combinational definitions only; no latency, no backpressure.
// Holds the default entry layout used by the fetch queue storage.
package fetch_pkg;

    localparam int FETCH_WIDTH = 32;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instr;
    } fetch_entry_t;

    localparam logic [1:0] IFQ_DEQ_NONE = 2'd0;
    localparam logic [1:0] IFQ_DEQ_ONE  = 2'd1;
    localparam logic [1:0] IFQ_DEQ_TWO  = 2'd2;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode-facing bundle of the instruction fetch queue.
// Wires only; no latency. Backpressure is carried on stall.
// master = fetch + decode side, slave = the queue itself.
interface inst_fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             enq_valid;
    logic [WIDTH-1:0] enq_pc;
    logic [WIDTH-1:0] enq_instr;
    logic             stall;
    logic [1:0]       deq_n;
    logic             valid0;
    logic             valid1;
    logic [WIDTH-1:0] pc0;
    logic [WIDTH-1:0] instr0;
    logic [WIDTH-1:0] pc1;
    logic [WIDTH-1:0] instr1;
    logic [CW-1:0]    count;

    modport master (
        output enq_valid, enq_pc, enq_instr, deq_n,
        input  stall, valid0, valid1, pc0, instr0, pc1, instr1, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, deq_n,
        output stall, valid0, valid1, pc0, instr0, pc1, instr1, count
    );
endinterface

// File: rtl/ifq_storage.sv
// Entry register array: one synchronous write port, two asynchronous read ports.
// Write visible on reads the cycle after the edge; reads are combinational.
// No backpressure; the controller owns pointers and occupancy.
module ifq_storage
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  entry_t        wr_dat,
    input  logic [PW-1:0] rd0_addr,
    input  logic [PW-1:0] rd1_addr,
    output entry_t        rd0_dat,
    output entry_t        rd1_dat
);

    // Data contents are don't-care until written, so the array has no reset.
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd0_dat = mem_q[rd0_addr];
    assign rd1_dat = mem_q[rd1_addr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: 1 enqueue/cycle from fetch, 0-2 retire/cycle to decode.
// Latency 1 cycle enqueue-to-slot; 0 cycles when IFQ_BYPASS_EN is defined and the queue is empty.
// Backpressure: stall while full, from registered occupancy only; flush clears everything.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    inst_fetch_queue_if.slave   ifq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic [1:0]    deq_c;
    logic [CW-1:0] deq_w;
    logic [CW-1:0] deq_eff;
    logic          enq_acc;
    logic          wr_en;
    logic          byp;
    logic          byp_take;
    entry_t        wr_dat;
    entry_t        rd0_dat;
    entry_t        rd1_dat;

    assign full    = (count_q == CW'(DEPTH));
    assign deq_c   = (ifq.deq_n > IFQ_DEQ_TWO) ? IFQ_DEQ_TWO : ifq.deq_n;
    assign deq_w   = CW'(deq_c);
    assign deq_eff = (deq_w < count_q) ? deq_w : count_q;
    assign enq_acc = ifq.enq_valid && !full;

`ifdef IFQ_BYPASS_EN
    assign byp      = ifq.enq_valid && !flush && (count_q == '0);
    assign byp_take = byp && (deq_c != IFQ_DEQ_NONE);
`else
    assign byp      = 1'b0;
    assign byp_take = 1'b0;
`endif

    // An entry consumed straight through the bypass never touches storage.
    assign wr_en  = enq_acc && !byp_take && !flush;
    assign wr_dat = '{pc: ifq.enq_pc, instr: ifq.enq_instr};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + deq_eff[PW-1:0];
            tail_d  = tail_q + PW'(wr_en);
            count_d = count_q + CW'(wr_en) - deq_eff;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    ifq_storage #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_storage (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (tail_q),
        .wr_dat   (wr_dat),
        .rd0_addr (head_q),
        .rd1_addr (head_q + PW'(1)),
        .rd0_dat  (rd0_dat),
        .rd1_dat  (rd1_dat)
    );

    assign ifq.stall  = full;
    assign ifq.count  = count_q;
    assign ifq.valid0 = (count_q != '0) || byp;
    assign ifq.valid1 = (count_q >= CW'(2));
    assign ifq.pc0    = byp ? ifq.enq_pc    : rd0_dat.pc;
    assign ifq.instr0 = byp ? ifq.enq_instr : rd0_dat.instr;
    assign ifq.pc1    = rd1_dat.pc;
    assign ifq.instr1 = rd1_dat.instr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic against a queue-based model.
// Honours IFQ_BYPASS_EN the same way the design does.
module tb_inst_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    inst_fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) ifq ();

    inst_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .ifq   (ifq)
    );

    always #5 clk = ~clk;

    fetch_entry_t model_q[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'h1300_0013;
    endfunction

    // One cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input bit f, input bit ev, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [1:0] dn);
        int  dq;
        int  sz;
        bit  byp;
        bit  acc;
        flush         = f;
        ifq.enq_valid = ev;
        ifq.enq_pc    = pc;
        ifq.enq_instr = ins;
        ifq.deq_n     = dn;
        @(negedge clk);
        sz  = model_q.size();
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = ev && !f && (sz == 0);
`endif
        chk("count",  64'(ifq.count),  64'(sz));
        chk("stall",  64'(ifq.stall),  64'(sz == DEPTH));
        chk("valid0", 64'(ifq.valid0), 64'(sz >= 1 || byp));
        chk("valid1", 64'(ifq.valid1), 64'(sz >= 2));
        if (byp) begin
            chk("byp_pc0",    64'(ifq.pc0),    64'(pc));
            chk("byp_instr0", 64'(ifq.instr0), 64'(ins));
        end else if (sz >= 1) begin
            chk("pc0",    64'(ifq.pc0),    64'(model_q[0].pc));
            chk("instr0", 64'(ifq.instr0), 64'(model_q[0].instr));
        end
        if (sz >= 2) begin
            chk("pc1",    64'(ifq.pc1),    64'(model_q[1].pc));
            chk("instr1", 64'(ifq.instr1), 64'(model_q[1].instr));
        end
        @(posedge clk);
        if (f) begin
            model_q.delete();
        end else begin
            dq  = (dn == 2'd3) ? 2 : int'(dn);
            acc = ev && (sz < DEPTH);
            if (!(byp && dq >= 1)) begin
                if (dq > sz) dq = sz;
                repeat (dq) void'(model_q.pop_front());
                if (acc) model_q.push_back('{pc: pc, instr: ins});
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] rpc;
        bit          ev;
        bit          fl;
        logic [1:0]  dn;

        reset = 1'b1;
        flush = 1'b0;
        ifq.enq_valid = 1'b0;
        ifq.enq_pc    = '0;
        ifq.enq_instr = '0;
        ifq.deq_n     = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",  64'(ifq.count),  64'd0);
        chk("rst_valid0", 64'(ifq.valid0), 64'd0);
        chk("rst_valid1", 64'(ifq.valid1), 64'd0);
        chk("rst_stall",  64'(ifq.stall),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle(5);

        // Fill to full, then a rejected 9th enqueue.
        for (int i = 0; i < DEPTH; i++) begin
            pc = 32'(i * 4);
            step(1'b0, 1'b1, pc, mk_instr(pc), 2'd0);
        end
        step(1'b0, 1'b1, 32'h20, mk_instr(32'h20), 2'd0);
        chk("full_stall", 64'(ifq.stall), 64'd1);
        chk("full_pc0",   64'(ifq.pc0),   64'h0);
        chk("full_pc1",   64'(ifq.pc1),   64'h4);

        // Dual drain while the write pointer wraps.
        pc = 32'h20;
        for (int i = 0; i < 4; i++) begin
            ev = (model_q.size() < DEPTH);
            step(1'b0, 1'b1, pc, mk_instr(pc), 2'd2);
            if (ev) pc = pc + 32'd4;
        end
        while (model_q.size() > 0) step(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        idle(1);

        // Over-request on a single entry.
        step(1'b0, 1'b1, 32'h40, mk_instr(32'h40), 2'd0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
        idle(1);
        chk("ovr_count", 64'(ifq.count), 64'd0);

        // Flush wins over a same-cycle enqueue and dequeue.
        for (int i = 0; i < 5; i++) begin
            pc = 32'h100 + 32'(i * 4);
            step(1'b0, 1'b1, pc, mk_instr(pc), 2'd0);
        end
        step(1'b1, 1'b1, 32'h999, mk_instr(32'h999), 2'd1);
        idle(2);

        // Enqueue into an empty queue with a same-cycle dequeue request.
        step(1'b0, 1'b1, 32'h80, mk_instr(32'h80), 2'd1);
        idle(2);

        // Random traffic, alternating draining and filling phases, with one mid-run reset.
        rpc = 32'h1000;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                flush = 1'b0;
                ifq.enq_valid = 1'b0;
                ifq.deq_n = 2'd0;
                #2 reset = 1'b1;
                #1;
                chk("arst_count",  64'(ifq.count),  64'd0);
                chk("arst_valid0", 64'(ifq.valid0), 64'd0);
                chk("arst_stall",  64'(ifq.stall),  64'd0);
                model_q.delete();
                @(negedge clk);
                reset = 1'b0;
                @(posedge clk);
                #1;
            end
            ev = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            if (((i / 100) % 2) == 1)
                dn = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom_range(0, 3));
            else
                dn = 2'($urandom_range(0, 3));
            if (ev && model_q.size() < DEPTH) rpc = rpc + 32'd4;
            step(fl, ev, rpc, $urandom, dn);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
